// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and baud divider helpers.
// The transmitter derives its bit period from the same helpers so both ends agree.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } uart_state_e;

   function automatic int unsigned uart_divider(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

   function automatic int unsigned uart_half(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
      return uart_divider(clk_freq, baud_rate) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin; resets to the idle (high) level.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready hold register, framing and overrun flags.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting around mid-bit.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 25000000,
   parameter int unsigned BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   input  logic       err_clr
);

   localparam int unsigned DIVIDER = uart_divider(CLK_FREQ, BAUD_RATE);
   localparam int unsigned HALF    = uart_half(CLK_FREQ, BAUD_RATE);
   localparam int          CW      = $clog2(DIVIDER);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDER - 1);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [CW-1:0] CNT_SAMPLE = CW'(HALF + 1);
`else
   localparam logic [CW-1:0] CNT_SAMPLE = CW'(HALF);
`endif

   logic rx_s;
   logic sample;
   logic at_sample, at_last;
   logic deliver, overrun_set;
   logic [CW-1:0] count_adv;

   uart_state_e   state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;

   uart_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   // hist_q holds rx_s from the two cycles before the sample point
   logic [1:0] hist_q, hist_d;

   always_comb begin
      hist_d = {hist_q[0], rx_s};
      sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
   end
`else
   always_comb begin
      sample = rx_s;
   end
`endif

   always_comb begin
      at_sample = (count_q == CNT_SAMPLE);
      at_last   = (count_q == CNT_LAST);
      count_adv = at_last ? '0 : count_q + CW'(1);
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      deliver     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            count_d   = '0;
            bit_idx_d = '0;
            if (!rx_s) state_d = ST_START;
         end
         ST_START: begin
            count_d = count_adv;
            if (at_sample && sample) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else if (at_last) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            count_d = count_adv;
            if (at_sample) shift_d = {sample, shift_q[7:1]};
            if (at_last) begin
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = ST_STOP;
            end
         end
         // Leave mid-stop-bit so the next start edge is caught even with baud skew
         ST_STOP: begin
            count_d = count_adv;
            if (at_sample) begin
               count_d = '0;
               if (sample) begin
                  deliver = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            count_d = '0;
            if (rx_s) state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            count_d   = '0;
            bit_idx_d = '0;
         end
      endcase
   end

   // A byte finishing while the old one is unconsumed is dropped and flagged
   always_comb begin
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      overrun_set = 1'b0;
      if (deliver) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_set = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
      overrun_d = overrun_set | (overrun_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
         hist_q      <= 2'b11;
`endif
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_MAJORITY_EN
         hist_q      <= hist_d;
`endif
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIVIDER=10; a scoreboard queue holds the bytes expected
// at the valid/ready handshake. Extra glitch case when UART_RX_MAJORITY_EN is defined.
module tb_uart_rx;

   localparam int unsigned CLK_FREQ  = 1000000;
   localparam int unsigned BAUD_RATE = 100000;
   localparam int          DIV       = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rx_ready;
   logic       err_clr;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   uart_rx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       stop_ok;
   } vec_t;

   int         checks = 0;
   int         failures = 0;
   int         cycle = 0;
   int         fe_count = 0;
   int         valid_rises = 0;
   int         last_rise_cycle = 0;
   logic       valid_prev = 1'b0;
   logic [7:0] exp_q[$];
   vec_t       vecs[6];

   always @(posedge clk) cycle++;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Every handshake must consume the oldest expected byte
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) fe_count++;
         if (rx_valid && !valid_prev) begin
            valid_rises++;
            last_rise_cycle = cycle;
         end
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_byte: got 0x%02h expected none", rx_data);
            end else begin
               checkOutput("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
         end
      end
      valid_prev = rx_valid;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic driveBit(input logic v, input int n);
      rx = v;
      repeat (n) step();
   endtask

   // glitch_pos selects a frame bit (0=start, 9=stop) that gets a 1-cycle inversion mid-bit
   task automatic sendFrame(input logic [7:0] d, input logic stop_v, input int glitch_pos);
      logic [9:0] fr;
      fr = {stop_v, d, 1'b0};
      for (int p = 0; p < 10; p++) begin
         if (p == glitch_pos) begin
            rx = fr[p];
            repeat (6) step();
            rx = ~fr[p];
            step();
            rx = fr[p];
            repeat (3) step();
         end else begin
            driveBit(fr[p], DIV);
         end
      end
      rx = 1'b1;
   endtask

   task automatic applyStimulus(input vec_t v, input logic check_latency);
      int fe0, vr0, c0, lat;
      fe0 = fe_count;
      vr0 = valid_rises;
      if (v.stop_ok) exp_q.push_back(v.data);
      c0 = cycle;
      sendFrame(v.data, v.stop_ok, -1);
      repeat (15) step();
      checkOutput("frame_err_count", 32'(fe_count - fe0), v.stop_ok ? 32'd0 : 32'd1);
      checkOutput("valid_pulses", 32'(valid_rises - vr0), v.stop_ok ? 32'd1 : 32'd0);
      checkOutput("byte_delivered", 32'(exp_q.size()), 32'd0);
      if (check_latency) begin
         lat = last_rise_cycle - c0;
         checkOutput("latency_window", 32'(lat >= 96 && lat <= 102), 32'd1);
      end
   endtask

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int fe0, vr0;
      rst      = 1'b1;
      rx       = 1'b1;
      rx_ready = 1'b1;
      err_clr  = 1'b0;
      repeat (3) step();
      checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
      checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
      checkOutput("reset_overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      repeat (5) step();

      $display("[TB] table-driven frames");
      vecs[0] = '{8'h55, 1'b1};
      vecs[1] = '{8'hA3, 1'b1};
      vecs[2] = '{8'h00, 1'b1};
      vecs[3] = '{8'hFF, 1'b1};
      vecs[4] = '{8'h0F, 1'b0};
      vecs[5] = '{8'h81, 1'b1};
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i == 0);
      checkOutput("overrun_after_table", 32'(overrun), 32'd0);

      $display("[TB] overrun sequence");
      rx_ready = 1'b0;
      exp_q.push_back(8'h12);
      sendFrame(8'h12, 1'b1, -1);
      repeat (5) step();
      checkOutput("hold_valid", 32'(rx_valid), 32'd1);
      checkOutput("no_overrun_yet", 32'(overrun), 32'd0);
      sendFrame(8'h34, 1'b1, -1);
      repeat (15) step();
      checkOutput("hold_data_kept", 32'(rx_data), 32'h12);
      checkOutput("overrun_set", 32'(overrun), 32'd1);
      rx_ready = 1'b1;
      step();
      checkOutput("valid_dropped", 32'(rx_valid), 32'd0);
      checkOutput("overrun_sticky", 32'(overrun), 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      checkOutput("overrun_cleared", 32'(overrun), 32'd0);
      checkOutput("overrun_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] break sequence");
      fe0 = fe_count;
      vr0 = valid_rises;
      driveBit(1'b0, DIV);
      for (int i = 0; i < 8; i++) driveBit(1'(8'h0F >> i), DIV);
      driveBit(1'b0, DIV + 30);
      rx = 1'b1;
      repeat (10) step();
      checkOutput("break_frame_err", 32'(fe_count - fe0), 32'd1);
      checkOutput("break_no_byte", 32'(valid_rises - vr0), 32'd0);
      exp_q.push_back(8'h81);
      sendFrame(8'h81, 1'b1, -1);
      repeat (15) step();
      checkOutput("after_break_byte", 32'(exp_q.size()), 32'd0);
      checkOutput("after_break_fe", 32'(fe_count - fe0), 32'd1);

      $display("[TB] start glitch");
      fe0 = fe_count;
      vr0 = valid_rises;
      rx = 1'b0;
      repeat (3) step();
      rx = 1'b1;
      repeat (40) step();
      checkOutput("glitch_no_valid", 32'(valid_rises - vr0), 32'd0);
      checkOutput("glitch_no_fe", 32'(fe_count - fe0), 32'd0);
      exp_q.push_back(8'hE7);
      sendFrame(8'hE7, 1'b1, -1);
      repeat (15) step();
      checkOutput("after_glitch_byte", 32'(exp_q.size()), 32'd0);
`ifdef UART_RX_MAJORITY_EN
      exp_q.push_back(8'hFF);
      sendFrame(8'hFF, 1'b1, 4);
      repeat (15) step();
      checkOutput("majority_glitch_byte", 32'(exp_q.size()), 32'd0);
`endif

      $display("[TB] reset mid-frame");
      rx_ready = 1'b0;
      sendFrame(8'h3C, 1'b1, -1);
      repeat (5) step();
      checkOutput("pre_reset_valid", 32'(rx_valid), 32'd1);
      checkOutput("pre_reset_data", 32'(rx_data), 32'h3C);
      driveBit(1'b0, DIV);
      for (int i = 0; i < 4; i++) driveBit(1'(8'h5A >> i), DIV);
      rx = 1'b1;
      repeat (5) step();
      rst = 1'b1;
      step();
      checkOutput("midframe_rst_data", 32'(rx_data), 32'd0);
      checkOutput("midframe_rst_valid", 32'(rx_valid), 32'd0);
      checkOutput("midframe_rst_fe", 32'(frame_err), 32'd0);
      checkOutput("midframe_rst_overrun", 32'(overrun), 32'd0);
      rst      = 1'b0;
      rx_ready = 1'b1;
      repeat (30) step();
      exp_q.push_back(8'hC6);
      sendFrame(8'hC6, 1'b1, -1);
      repeat (15) step();
      checkOutput("after_reset_byte", 32'(exp_q.size()), 32'd0);

      $display("[TB] loopback 0x00..0xFF");
      fe0 = fe_count;
      vr0 = valid_rises;
      for (int b = 0; b < 256; b++) begin
         exp_q.push_back(8'(b));
         sendFrame(8'(b), 1'b1, -1);
      end
      repeat (20) step();
      checkOutput("loopback_all_delivered", 32'(exp_q.size()), 32'd0);
      checkOutput("loopback_valid_pulses", 32'(valid_rises - vr0), 32'd256);
      checkOutput("loopback_no_fe", 32'(fe_count - fe0), 32'd0);
      checkOutput("loopback_no_overrun", 32'(overrun), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
